// File: rtl/bg_frame_controller_if.sv
// PE-array side of the frame controller: Start/Done/Ack handshake,
// per-PE colour sums in, expected background colour out.
interface bg_frame_controller_if #(
  parameter int NUM_PE = 4,
  parameter int SUM_W  = 16
);
  logic                    Start_Sum;
  logic                    Start_BgRemoval;
  logic                    Ack;
  logic [NUM_PE-1:0]       Qsd;
  logic [NUM_PE-1:0]       Qbgd;
  logic [NUM_PE*SUM_W-1:0] red_sum;
  logic [NUM_PE*SUM_W-1:0] green_sum;
  logic [NUM_PE*SUM_W-1:0] blue_sum;
  logic [7:0]              red_exp;
  logic [7:0]              green_exp;
  logic [7:0]              blue_exp;

  modport master (
    output Start_Sum, Start_BgRemoval, Ack,
    output red_exp, green_exp, blue_exp,
    input  Qsd, Qbgd,
    input  red_sum, green_sum, blue_sum
  );

  modport slave (
    input  Start_Sum, Start_BgRemoval, Ack,
    input  red_exp, green_exp, blue_exp,
    output Qsd, Qbgd,
    output red_sum, green_sum, blue_sum
  );
endinterface

// File: rtl/bg_frame_controller.sv
// Frame sequencer for the background-removal PE array.
// Define BGC_ROUND_EN for round-half-up averaging (default truncates).
module bg_frame_controller #(
  parameter int NUM_PE         = 4,
  parameter int SUM_W          = 16,
  parameter int LOG2_TOTAL_PIX = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Go,
  output logic                  Busy,
  output logic                  Done,
  bg_frame_controller_if.master pe
);

  localparam int ACC_W = SUM_W + $clog2(NUM_PE) + 1;
  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [3:0] {
    IDLE, SUM_START, SUM_WAIT, ACCUM, EXP,
    SUM_ACK, BG_START, BG_WAIT, BG_ACK, DONE
  } state_t;

  state_t state, state_n;

  logic [ACC_W-1:0] acc_r, acc_g, acc_b;
  logic [IDX_W-1:0] idx;
  logic             last_pe;

  assign last_pe = (idx == IDX_W'(NUM_PE - 1));

  function automatic logic [7:0] avg(input logic [ACC_W-1:0] a);
    logic [ACC_W:0] t;
    t = {1'b0, a};
`ifdef BGC_ROUND_EN
    t = t + ((ACC_W+1)'(1) << (LOG2_TOTAL_PIX - 1));
`endif
    t = t >> LOG2_TOTAL_PIX;
    return (t > (ACC_W+1)'(255)) ? 8'hFF : t[7:0];
  endfunction

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (Go) state_n = SUM_START;
      SUM_START: state_n = SUM_WAIT;
      SUM_WAIT:  if (&pe.Qsd) state_n = ACCUM;
      ACCUM:     if (last_pe) state_n = EXP;
      EXP:       state_n = SUM_ACK;
      SUM_ACK:   if (pe.Qsd == '0) state_n = BG_START;
      BG_START:  state_n = BG_WAIT;
      BG_WAIT:   if (&pe.Qbgd) state_n = BG_ACK;
      BG_ACK:    if (pe.Qbgd == '0) state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state              <= IDLE;
      pe.Start_Sum       <= 1'b0;
      pe.Start_BgRemoval <= 1'b0;
      pe.Ack             <= 1'b0;
      Busy               <= 1'b0;
      Done               <= 1'b0;
    end else begin
      state              <= state_n;
      pe.Start_Sum       <= (state_n == SUM_START);
      pe.Start_BgRemoval <= (state_n == BG_START);
      pe.Ack             <= (state_n == SUM_ACK) ||
                            (state_n == BG_ACK);
      Busy               <= (state_n != IDLE);
      Done               <= (state_n == DONE);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_r <= '0;
      acc_g <= '0;
      acc_b <= '0;
      idx   <= '0;
    end else if (state == SUM_START) begin
      acc_r <= '0;
      acc_g <= '0;
      acc_b <= '0;
      idx   <= '0;
    end else if (state == ACCUM) begin
      acc_r <= acc_r + ACC_W'(pe.red_sum[idx*SUM_W +: SUM_W]);
      acc_g <= acc_g + ACC_W'(pe.green_sum[idx*SUM_W +: SUM_W]);
      acc_b <= acc_b + ACC_W'(pe.blue_sum[idx*SUM_W +: SUM_W]);
      idx   <= idx + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pe.red_exp   <= '0;
      pe.green_exp <= '0;
      pe.blue_exp  <= '0;
    end else if (state == EXP) begin
      pe.red_exp   <= avg(acc_r);
      pe.green_exp <= avg(acc_g);
      pe.blue_exp  <= avg(acc_b);
    end
  end

endmodule
